// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word CPU accesses into whole-word memory
// reads and writes, with read-modify-write for sub-word stores and load extension.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, RESP} state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_e            state_q;
  logic              write_q, signed_q;
  logic [1:0]        size_q, lane_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
  logic [31:0]       resp_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              req_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ld_data_d, st_word_d;

  assign req_err = (req_size == 2'b11) ||
                   (req_size == SZ_H && req_addr[0]) ||
                   (req_size == SZ_W && req_addr[1:0] != 2'b00);

  assign lane_b = mem_rdata[{lane_q, 3'b000} +: 8];
  assign lane_h = mem_rdata[{lane_q[1], 4'b0000} +: 16];

  // Extended load result and merged store word, both formed from the read word in DATA
  always_comb begin
    ld_data_d = mem_rdata;
    st_word_d = mem_rdata;
    case (size_q)
      SZ_B: begin
        ld_data_d = {{24{signed_q & lane_b[7]}}, lane_b};
        st_word_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_H: begin
        ld_data_d = {{16{signed_q & lane_h[15]}}, lane_h};
        st_word_d[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      mem_addr_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          write_q    <= req_write;
          signed_q   <= req_signed;
          size_q     <= req_size;
          lane_q     <= req_addr[1:0];
          wdata_q    <= req_wdata;
          mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
          if (req_err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else if (req_write && req_size == SZ_W) begin
            state_q     <= WRITE;
            mem_write_q <= 1'b1;
            mem_wdata_q <= req_wdata;
          end else begin
            state_q    <= READ;
            mem_read_q <= 1'b1;
          end
        end
        READ: state_q <= DATA;
        DATA: if (write_q) begin
          state_q     <= WRITE;
          mem_write_q <= 1'b1;
          mem_wdata_q <= st_word_d;
        end else begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= ld_data_d;
        end
        WRITE: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
